q4_countdown: RTL and testbench
===============================

// Module: q4_countdown
// PURPOSE
//   Reverse-direction companion to the Q4 up-counter. It is loaded with an 8-bit
//   value and, while start is high, subtracts the 4-bit NumberIn once per clock.
//   It reports completion (done) on reaching exactly zero, or underflow if a step
//   exceeds the remaining count. It drains or checks a Q4 Count value in the HW1
//   datapath.
// PARAMETERS
//   WIDTH   8  width of LoadValue/Count
//   STEP_W  4  width of NumberIn (STEP_W < WIDTH)
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous, active-high reset
//   load       in   1       load LoadValue into Count (priority over start)
//   LoadValue  in   WIDTH   initial countdown value
//   start      in   1       run enable; low pauses countdown
//   NumberIn   in   STEP_W  decrement step, sampled every clock in RUN/IDLE
//   Count      out  WIDTH   current remaining value (registered)
//   busy       out  1       1 while state==RUN
//   done       out  1       1 while state==DONE
//   underflow  out  1       1 while state==HALT (sticky until load/rst)
// BEHAVIOUR
//   One clock domain; reset is asynchronous and active-high.
//   rst=1 (any time, async): Count=0, state=IDLE, busy=done=underflow=0.
//   All outputs are registered or decoded directly from the state register.
//   Outputs are glitch-free and change only on clk rising edge or rst.
//   States: IDLE, RUN, DONE, HALT. Per rising edge, first match wins:
//   - load=1 (any state): Count<=LoadValue; state<=IDLE. No subtract this edge.
//   - IDLE:
//       start=0 -> hold.
//       start=1 and Count==0 -> DONE, Count holds.
//       start=1 and Count!=0 -> apply the step rule below.
//   - RUN:
//       start=0 -> IDLE, Count holds (pause).
//       start=1 -> apply the step rule.
//   - Step rule (d = zero-extended NumberIn):
//       d==0       -> Count holds; state<=RUN.
//       d<Count    -> Count<=Count-d; state<=RUN.
//       d==Count   -> Count<=0; state<=DONE.
//       d>Count    -> Count<=(Count-d) mod 2^WIDTH (wrapped); state<=HALT.
//   - DONE, HALT: Count frozen; start and NumberIn ignored; exit only via load or rst.
//   Latency: the subtraction result is visible on Count one edge after start/NumberIn
//   are sampled. done/underflow assert on the same edge that produces the final Count.
//   Subtraction is WIDTH bits; underflow detection uses a WIDTH+1-bit borrow.
// TESTING (clk period 50 ns)
//   1. rst pulse mid-RUN (Count=60), asynchronous to clk
//      -> Count=0 and busy=0 immediately; state IDLE after release.
//   2. load 100, start=1, NumberIn=4
//      -> Count=96,92,...,4,0; done=1 on the 25th edge; Count stays 0 afterwards.
//   3. load 10, start=1, NumberIn=4
//      -> Count=6,2, then 254 with underflow=1; Count frozen at 254 and
//         done=0 thereafter.
//   4. load 50, NumberIn=5, start=1 for 3 edges, then 0 for 4 edges, then 1
//      -> Count 45,40,35, held at 35 with busy=0, then resumes at 30.
//   5. RUN at Count=20, load=1 with LoadValue=77, start=1
//      -> Count=77 and state IDLE on that edge; no decrement that edge;
//         next edge Count=77-NumberIn.
//   6. load 0, start=1; then load 9 from DONE
//      -> done=1 one edge after start with Count=0; load clears done, Count=9.

Source files
------------

// File: rtl/q4_countdown.sv
`default_nettype none
// ============================================================================
//  Module      : q4_countdown
//  Description : Loadable down-counter that subtracts a per-clock step while
//                enabled, flagging exact-zero completion or underflow.
//  Revision    : 1.0  initial release
// ============================================================================
module q4_countdown #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WIDTH-1:0]  LoadValue,
    input  logic              start,
    input  logic [STEP_W-1:0] NumberIn,
    output logic [WIDTH-1:0]  Count,
    output logic              busy,
    output logic              done,
    output logic              underflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;

    logic [WIDTH-1:0] w_step;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;

    assign w_step   = {{(WIDTH-STEP_W){1'b0}}, NumberIn};
    // Extra MSB captures the borrow when the step exceeds the remaining count.
    assign w_diff   = {1'b0, count_q} - {1'b0, w_step};
    assign w_borrow = w_diff[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (load) begin
            count_d = LoadValue;
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_RUN: begin
                    if (!start) begin
                        state_d = S_IDLE;
                    end else if ((state_q == S_IDLE) && (count_q == '0)) begin
                        state_d = S_DONE;
                    end else if (w_step == '0) begin
                        state_d = S_RUN;
                    end else if (w_borrow) begin
                        count_d = w_diff[WIDTH-1:0];
                        state_d = S_HALT;
                    end else if (w_diff[WIDTH-1:0] == '0) begin
                        count_d = '0;
                        state_d = S_DONE;
                    end else begin
                        count_d = w_diff[WIDTH-1:0];
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    assign Count     = count_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign underflow = (state_q == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_q4_countdown.sv
`default_nettype none
// ============================================================================
//  Module      : tb_q4_countdown
//  Description : Directed and randomized self-checking bench for q4_countdown.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_q4_countdown;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] LoadValue;
    logic       start;
    logic [3:0] NumberIn;
    logic [7:0] Count;
    logic       busy;
    logic       done;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining value plus three status flags.
    int m_cnt     = 0;
    bit m_running = 0;
    bit m_done    = 0;
    bit m_halt    = 0;

    q4_countdown #(.WIDTH(8), .STEP_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .LoadValue (LoadValue),
        .start     (start),
        .NumberIn  (NumberIn),
        .Count     (Count),
        .busy      (busy),
        .done      (done),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_running = 0; m_done = 0; m_halt = 0;
    endtask

    task automatic model_edge(input bit l, input int lv, input bit s, input int d);
        if (l) begin
            m_cnt = lv; m_running = 0; m_done = 0; m_halt = 0;
        end else if (m_done || m_halt) begin
            // frozen until load or reset
        end else if (!s) begin
            m_running = 0;
        end else if (!m_running && m_cnt == 0) begin
            m_done = 1;
        end else if (d == 0) begin
            m_running = 1;
        end else if (d < m_cnt) begin
            m_cnt = m_cnt - d; m_running = 1;
        end else if (d == m_cnt) begin
            m_cnt = 0; m_done = 1; m_running = 0;
        end else begin
            m_cnt = (m_cnt - d + 256) % 256; m_halt = 1; m_running = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".Count"},     int'(Count),     m_cnt);
        chk({tag, ".busy"},      int'(busy),      int'(m_running));
        chk({tag, ".done"},      int'(done),      int'(m_done));
        chk({tag, ".underflow"}, int'(underflow), int'(m_halt));
    endtask

    // One clock: drive at the falling edge, update model on the rising edge,
    // compare just after it.
    task automatic cyc(input string tag, input bit l, input int lv, input bit s, input int d);
        @(negedge clk);
        load = l; LoadValue = 8'(lv); start = s; NumberIn = 4'(d);
        @(posedge clk);
        model_edge(l, lv, s, d);
        #1;
        check_all(tag);
    endtask

    initial begin
        int edges;
        rst = 1'b1; load = 1'b0; LoadValue = '0; start = 1'b0; NumberIn = '0;
        #60;
        chk("reset.Count", int'(Count), 0);
        chk("reset.busy",  int'(busy),  0);
        @(negedge clk);
        rst = 1'b0;
        cyc("idle_hold", 0, 0, 0, 0);

        // Asynchronous reset in the middle of a run at Count=60.
        cyc("t1_load", 1, 80, 0, 0);
        for (int i = 0; i < 4; i++) cyc("t1_run", 0, 0, 1, 5);
        chk("t1_pre_cnt", int'(Count), 60);
        #7 rst = 1'b1;
        #1;
        model_reset();
        chk("t1_async_cnt",  int'(Count), 0);
        chk("t1_async_busy", int'(busy),  0);
        #13 rst = 1'b0;
        cyc("t1_after", 0, 0, 0, 0);

        // 100 down by 4: done on the 25th edge.
        cyc("t2_load", 1, 100, 0, 0);
        edges = 0;
        for (int i = 0; i < 26 && !done; i++) begin
            cyc("t2_run", 0, 0, 1, 4);
            edges++;
        end
        chk("t2_done_edge", edges, 25);
        for (int i = 0; i < 3; i++) cyc("t2_stay", 0, 0, 1, 4);

        // 10 down by 4: underflow to 254, then frozen.
        cyc("t3_load", 1, 10, 0, 0);
        for (int i = 0; i < 3; i++) cyc("t3_run", 0, 0, 1, 4);
        chk("t3_wrap", int'(Count), 254);
        for (int i = 0; i < 3; i++) cyc("t3_frozen", 0, 0, 1, 7);

        // Pause and resume.
        cyc("t4_load", 1, 50, 0, 0);
        for (int i = 0; i < 3; i++) cyc("t4_run", 0, 0, 1, 5);
        for (int i = 0; i < 4; i++) cyc("t4_pause", 0, 0, 0, 5);
        chk("t4_held", int'(Count), 35);
        cyc("t4_resume", 0, 0, 1, 5);
        chk("t4_resumed", int'(Count), 30);

        // Load takes priority over a running subtract.
        cyc("t5_load", 1, 26, 0, 0);
        for (int i = 0; i < 2; i++) cyc("t5_run", 0, 0, 1, 3);
        cyc("t5_reload", 1, 77, 1, 3);
        chk("t5_no_dec", int'(Count), 77);
        cyc("t5_next", 0, 0, 1, 3);
        chk("t5_dec", int'(Count), 74);

        // Zero load then start, then reload out of DONE.
        cyc("t6_load0", 1, 0, 0, 0);
        cyc("t6_start", 0, 0, 1, 6);
        chk("t6_done", int'(done), 1);
        cyc("t6_reload", 1, 9, 1, 6);
        chk("t6_cnt9", int'(Count), 9);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit l;
            int lv;
            l  = ($urandom_range(0, 19) == 0);
            lv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 255);
            cyc("rand", l, lv, ($urandom_range(0, 4) != 0), $urandom_range(0, 15));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
